// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared widths and return-path owner encoding        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 4;
  localparam int WCNT_W       = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wait_counter : saturating refusal counter with clear and at_max   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [WCNT_W-1:0] CNT_MAX = WCNT_W'(MAX);

  logic [WCNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_port_arbiter : CPU / video sharing of a sync-read memory port |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   at_max;
  owner_t rown;

  wait_counter #(.MAX(MAX_WAIT)) u_wait_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (vid_req & ~vid_gnt),
    .clr    (~vid_req | vid_gnt),
    .at_max (at_max)
  );

  // CPU wins contention until video has been refused MAX_WAIT times.
  assign cpu_gnt   = rst_n & cpu_req & (~vid_req | ~at_max);
  assign vid_gnt   = rst_n & vid_req & (~cpu_req | at_max);
  assign cpu_stall = rst_n & cpu_req & ~cpu_gnt;

  assign mem_en    = cpu_gnt | vid_gnt;
  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_addr  = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rown <= OWN_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      rown <= OWN_CPU;
    end else if (vid_gnt) begin
      rown <= OWN_VID;
    end else begin
      rown <= OWN_NONE;
    end
  end

  // Gating with rst_n drops a read that was in flight when reset arrived.
  assign cpu_rvalid = rst_n & (rown == OWN_CPU);
  assign vid_rvalid = rst_n & (rown == OWN_VID);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vid_rdata  = vid_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed scoreboard bench for the arbiter   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        vid_req, vid_gnt, vid_rvalid;
  logic [15:0] vid_addr, vid_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [256];

  logic        chk, done, fin;
  logic        exp_cg, exp_vg, exp_stall;
  logic [15:0] cpu_q[$];
  logic [15:0] vid_q[$];
  int          checks, errors;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory with one cycle of read latency and no bypass.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares grants against the current expectation and pops the
  // read scoreboards whenever an rvalid shows up.
  always @(negedge clk) begin
    if (chk) begin
      cmp("cpu_gnt",   16'(cpu_gnt),   16'(exp_cg));
      cmp("vid_gnt",   16'(vid_gnt),   16'(exp_vg));
      cmp("cpu_stall", 16'(cpu_stall), 16'(exp_stall));
      cmp("mem_en",    16'(mem_en),    16'(exp_cg | exp_vg));
      if (exp_cg) begin
        cmp("mem_we_cpu",   16'(mem_we), 16'(cpu_we));
        cmp("mem_addr_cpu", mem_addr, cpu_addr);
        if (cpu_we) cmp("mem_wdata", mem_wdata, cpu_wdata);
      end
      if (exp_vg) begin
        cmp("mem_we_vid",   16'(mem_we), 16'd0);
        cmp("mem_addr_vid", mem_addr, vid_addr);
      end
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) cmp("cpu_rvalid_unexpected", 16'd1, 16'd0);
        else                   cmp("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end else begin
        cmp("cpu_rdata_gated", cpu_rdata, 16'd0);
      end
      if (vid_rvalid) begin
        if (vid_q.size() == 0) cmp("vid_rvalid_unexpected", 16'd1, 16'd0);
        else                   cmp("vid_rdata", vid_rdata, vid_q.pop_front());
      end else begin
        cmp("vid_rdata_gated", vid_rdata, 16'd0);
      end
    end
    if (done && !fin) begin
      cmp("cpu_reads_outstanding", 16'(cpu_q.size()), 16'd0);
      cmp("vid_reads_outstanding", 16'(vid_q.size()), 16'd0);
      fin = 1'b1;
    end
  end

  // One cycle of stimulus; expected read data is queued when a read grant is expected.
  task automatic cyc(input logic r, input logic creq, input logic cwe,
                     input logic [15:0] ca, input logic [15:0] cd,
                     input logic vreq, input logic [15:0] va,
                     input logic egc, input logic egv,
                     input logic [15:0] ecd, input logic [15:0] evd, input logic pr);
    rst_n     = r;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = ca;
    cpu_wdata = cd;
    vid_req   = vreq;
    vid_addr  = va;
    exp_cg    = egc;
    exp_vg    = egv;
    exp_stall = r & creq & ~egc;
    if (pr && egc && !cwe) cpu_q.push_back(ecd);
    if (pr && egv)         vid_q.push_back(evd);
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    chk = 1'b0; done = 1'b0; fin = 1'b0;
    exp_cg = 1'b0; exp_vg = 1'b0; exp_stall = 1'b0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    @(posedge clk); #1;

    // Reset with both requesting: nothing may be granted.
    cyc(0, 1, 0, 16'h0030, 16'h0000, 1, 16'h0020, 0, 0, 16'h0, 16'h0, 1);
    cyc(0, 1, 0, 16'h0030, 16'h0000, 1, 16'h0020, 0, 0, 16'h0, 16'h0, 1);

    // First cycle out of reset: CPU wins, then preload memory.
    cyc(1, 1, 1, 16'h0001, 16'h1111, 1, 16'h0002, 1, 0, 16'h0, 16'h0, 1);
    cyc(1, 1, 1, 16'h0002, 16'h2222, 0, 16'h0000, 1, 0, 16'h0, 16'h0, 1);
    cyc(1, 1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0, 16'h0, 1);
    cyc(1, 1, 1, 16'h0020, 16'h5A5A, 0, 16'h0000, 1, 0, 16'h0, 16'h0, 1);
    cyc(1, 1, 1, 16'h0030, 16'h3C3C, 0, 16'h0000, 1, 0, 16'h0, 16'h0, 1);

    // Read back the written word.
    cyc(1, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 16'hBEEF, 16'h0, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);

    // Continuous contention: CPU x4, video on the 5th, repeating.
    for (int k = 0; k < 10; k++)
      cyc(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0020, (k % 5) != 4, (k % 5) == 4,
          16'h3C3C, 16'h5A5A, 1);

    // Alternating owners on consecutive cycles.
    cyc(1, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 1, 0, 16'h1111, 16'h0, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 1, 16'h0, 16'h2222, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);

    // Video abandons after two refusals, then must wait the full count again.
    cyc(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0020, 1, 0, 16'h3C3C, 16'h0, 1);
    cyc(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0020, 1, 0, 16'h3C3C, 16'h0, 1);
    cyc(1, 1, 0, 16'h0030, 16'h0000, 0, 16'h0000, 1, 0, 16'h3C3C, 16'h0, 1);
    for (int k = 0; k < 5; k++)
      cyc(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0020, k != 4, k == 4,
          16'h3C3C, 16'h5A5A, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);

    // Read granted, then reset before its data returns: no rvalid.
    cyc(1, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 1, 0, 16'h0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);

    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port, synchronous-read data memory between two requesters. The CPU data port carries MOVMR/MOVRM/MOVMRI/MOVRMI/PUSH/POP traffic. The video/IO read port is the second requester. The block grants one access per cycle, routes read data back to the owner one cycle later, and raises a stall to the CPU while it is refused. A bounded-wait counter guarantees the video port is served under continuous CPU traffic.

## Interface
- ADDR_W, 16, memory address width (matches Control Addr)
- DATA_W, 16, memory data width
- MAX_WAIT, 4, refused video cycles (1..15) before video takes priority
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write (MemWrite), 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued to memory this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  cpu_rdata valid (cycle after granted read)
- cpu_rdata  out  DATA_W  read data to CPU
- vid_req  in  1  video read request, held until granted
- vid_addr  in  ADDR_W  video address
- vid_gnt  out  1  video read issued this cycle
- vid_rvalid  out  1  vid_rdata valid
- vid_rdata  out  DATA_W  read data to video
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency after mem_en & ~mem_we

## Operation
- **Grant decision:** combinational from current requests and the registered wait counter `wcnt`.
  - Only cpu_req → CPU.
  - Only vid_req → video.
  - Both, `wcnt < MAX_WAIT` → CPU.
  - Both, `wcnt == MAX_WAIT` → video.
  - Neither → idle, mem_en = 0.
- **Memory drive:** granted port drives mem_addr. mem_we = cpu_we only when CPU is granted; the video port never writes. mem_wdata = cpu_wdata when CPU is granted, else 0.
- **wcnt:**
  - Increments when vid_req & ~vid_gnt, saturating at MAX_WAIT.
  - Clears to 0 on vid_gnt or when vid_req = 0.
- **Return-path register `rown`:** values NONE/CPU/VID. Loaded each cycle with the owner of a granted read; NONE on write or idle.
- **Read return:**
  - cpu_rvalid = (rown == CPU). vid_rvalid = (rown == VID).
  - Both rdata outputs are mem_rdata gated to 0 when their rvalid is low.
- **Back-to-back:** reads from alternating owners each cycle are legal and return in order, one per cycle.
- **Requester protocol:** a requester must hold req/addr/data stable until granted. A request dropped before grant is abandoned with no side effect.
- **Reset:** rst_n = 0 for one edge sets `wcnt` = 0 and `rown` = NONE. A read granted in the cycle before reset returns no rvalid.
- **Reset values:** gnt, stall, mem_* and rvalid are all 0 during reset. Grants are forced 0 while rst_n = 0.

## Timing
- Grant latency: 0 cycles (same cycle as req when winning).
- Read data latency: 1 cycle after grant.
- Write completion: at the grant edge, with no response.
- Video worst-case wait: MAX_WAIT cycles of refusal, granted on the (MAX_WAIT+1)th cycle of a continuous request.
- CPU worst case: one stall cycle per forced video grant.
- A CPU read followed by a CPU write to the same address on consecutive cycles returns the old data. The memory has no bypass and none is added.

## Structure
- Shared package `mem_arb_pkg`:
  - owner enum NONE = 2'd0, CPU = 2'd1, VID = 2'd2
  - default widths
- Sub-module `wait_counter`: saturating counter with inc/clr inputs and an `at_max` output. The rest stays flat in mem_port_arbiter.

## Test plan
- **Reset:** hold rst_n = 0 with cpu_req = vid_req = 1 → all gnt/rvalid/mem_en = 0. After release, CPU is granted first and wcnt starts at 0.
- **CPU write/read:** write addr 0x0010 data 0xBEEF, then read 0x0010 → gnt in each request cycle, cpu_rvalid = 1 with cpu_rdata = 0xBEEF one cycle after the read grant, no vid_rvalid.
- **Contention, MAX_WAIT = 4:** cpu_req and vid_req held high continuously →
  - CPU granted cycles 0–3.
  - Video granted cycle 4 with cpu_stall = 1.
  - Pattern repeats every 5 cycles.
  - vid_rvalid lands on cycles 5, 10, ….
- **Alternating reads:** CPU read 0x0001 (mem 0x1111) in cycle n, video read 0x0002 (mem 0x2222) in cycle n+1 → cpu_rdata 0x1111 at n+1 and vid_rdata 0x2222 at n+2, with no cross-delivery.
- **Video abandon:** vid_req high 2 refused cycles, then low 1 cycle, then high again → wcnt returns to 0, and video waits the full MAX_WAIT again.
- **Reset mid-read:** CPU read granted in cycle n, rst_n = 0 at the n+1 edge → cpu_rvalid stays 0.
